// File: rtl/pipe_slice_pkg.sv
// pipe_slice_pkg: shared state encoding and sizing for the pipeline slice
package pipe_slice_pkg;

    localparam int PS_OCC_W = 2;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_BUSY  = 2'b01,
        PS_FULL  = 2'b10
    } pipe_slice_state_t;

    function automatic logic [PS_OCC_W-1:0] ps_occ(input pipe_slice_state_t s);
        return (s == PS_FULL) ? PS_OCC_W'(2) : (s == PS_BUSY) ? PS_OCC_W'(1) : PS_OCC_W'(0);
    endfunction

endpackage

// File: rtl/pipe_slice_if.sv
// pipe_slice_if: valid/ready handshake bundle between two adjacent pipeline stages
interface pipe_slice_if #(
    parameter int WIDTH = 32
);
    import pipe_slice_pkg::*;

    logic                flush;
    logic                in_valid;
    logic [WIDTH-1:0]    in_data;
    logic                in_ready;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic                out_ready;
    logic [PS_OCC_W-1:0] occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_slice_dreg.sv
// pipe_dreg: payload register with sync reset, clear-to-RESET_VAL and load enable
module pipe_dreg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // reset and clear both return the payload to its idle value; otherwise load on enable
    always_ff @(posedge clk) begin
        if (rst || clr) q <= RESET_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/pipe_slice.sv
// pipe_slice: valid/ready pipeline stage register with flush; skid buffer built when PIPE_SLICE_SKID_EN is defined
module pipe_slice
    import pipe_slice_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    pipe_slice_if.slave  bus
);

    pipe_slice_state_t state, state_n;
    logic              main_en;
    logic              in_fire;
    logic [WIDTH-1:0]  main_d;

    assign in_fire       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = state != PS_EMPTY;

`ifdef PIPE_SLICE_SKID_EN
    logic             skid_en;
    logic             load_skid;
    logic             in_ready_q;
    logic [WIDTH-1:0] skid_q;

    // ready comes straight from a flop so a downstream stall never chains combinationally upstream
    assign bus.in_ready  = in_ready_q;
    assign bus.occupancy = ps_occ(state);
    assign main_d        = load_skid ? skid_q : bus.in_data;

    pipe_dreg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .en  (skid_en),
        .d   (bus.in_data),
        .q   (skid_q)
    );
`else
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign bus.occupancy = {1'b0, state == PS_BUSY};
    assign main_d        = bus.in_data;
`endif

    pipe_dreg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .en  (main_en),
        .d   (main_d),
        .q   (bus.out_data)
    );

    // next state and register load strobes from the handshake; main always holds the oldest entry
    always_comb begin
        state_n = state;
        main_en = 1'b0;
`ifdef PIPE_SLICE_SKID_EN
        skid_en   = 1'b0;
        load_skid = 1'b0;
`endif
        case (state)
            PS_EMPTY: begin
                if (in_fire) begin
                    state_n = PS_BUSY;
                    main_en = 1'b1;
                end
            end
            PS_BUSY: begin
                if (in_fire && bus.out_ready) main_en = 1'b1;
`ifdef PIPE_SLICE_SKID_EN
                else if (in_fire) begin
                    state_n = PS_FULL;
                    skid_en = 1'b1;
                end
`endif
                else if (bus.out_ready) state_n = PS_EMPTY;
            end
`ifdef PIPE_SLICE_SKID_EN
            PS_FULL: begin
                if (bus.out_ready) begin
                    state_n   = PS_BUSY;
                    main_en   = 1'b1;
                    load_skid = 1'b1;
                end
            end
`endif
            default: state_n = PS_EMPTY;
        endcase
    end

    // state register; reset and flush both squash every held entry
    always_ff @(posedge clk) begin
        state <= (rst || bus.flush) ? PS_EMPTY : state_n;
`ifdef PIPE_SLICE_SKID_EN
        in_ready_q <= rst || bus.flush || state_n != PS_FULL;
`endif
    end

endmodule
